// File: rtl/xor_lut_unit.sv
// xor_lut_unit: parity (XOR-reduce) primitive built from explicit K-input
// LUT-sized XOR cells, arranged as a combinational reduction tree.
// Provides a combinational parity plus a one-cycle registered parity with valid.
module xor_lut_unit #(
  parameter int WIDTH       = 6,
  parameter int TARGET_CHIP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             dout_comb,
  output logic             dout,
  output logic             dout_valid
);

  // Parameter legality; the tree sizing below uses a clamped width so that
  // the sizing functions always terminate, even when elaboration is about
  // to be aborted.
  localparam bit PARAMS_OK = (WIDTH >= 1) && (WIDTH <= 36) &&
                             ((TARGET_CHIP == 1) || (TARGET_CHIP == 2));
  localparam int K      = (TARGET_CHIP == 2) ? 6 : 4;
  localparam int W_SAFE = (WIDTH < 1) ? 1 : ((WIDTH > 36) ? 36 : WIDTH);

  // Number of nodes present at tree level lvl (level 0 = the raw din bits).
  function automatic int level_cnt(input int lvl);
    int c;
    c = W_SAFE;
    for (int i = 0; i < lvl; i++) begin
      c = (c + K - 1) / K;
    end
    return c;
  endfunction

  // Number of cell levels; at least one, so WIDTH<=K still uses one cell.
  function automatic int num_levels(input int w);
    int c;
    int n;
    c = (w + K - 1) / K;
    n = 1;
    while (c > 1) begin
      c = (c + K - 1) / K;
      n = n + 1;
    end
    return n;
  endfunction

  // Offset of the first node of level lvl inside the flat node vector.
  function automatic int level_off(input int lvl);
    int off;
    off = 0;
    for (int i = 0; i < lvl; i++) begin
      off = off + level_cnt(i);
    end
    return off;
  endfunction

  // One LUT cell: XOR of its K inputs (unused inputs arrive tied to 0).
  function automatic logic lut_xor(input logic [K-1:0] bits);
    return ^bits;
  endfunction

  localparam int NLVL  = num_levels(W_SAFE);
  localparam int TOTAL = level_off(NLVL + 1);

  if (!PARAMS_OK) begin : g_bad_params
    $fatal(1, "xor_lut_unit: illegal parameters WIDTH=%0d TARGET_CHIP=%0d (WIDTH 1..36, TARGET_CHIP 1 or 2)",
           WIDTH, TARGET_CHIP);
  end

  // Flat storage of every tree node, level by level; the last bit is the root.
  logic [TOTAL-1:0] node;

  assign node[WIDTH-1:0] = din;

  // Each level packs the previous level LSB-first into K-input cells; the
  // final cell of a level may be partially filled and has its spare inputs
  // tied low so the parity is unaffected.
  for (genvar l = 1; l <= NLVL; l++) begin : g_lvl
    localparam int N_IN    = level_cnt(l - 1);
    localparam int N_OUT   = level_cnt(l);
    localparam int OFF_IN  = level_off(l - 1);
    localparam int OFF_OUT = level_off(l);
    for (genvar c = 0; c < N_OUT; c++) begin : g_cell
      logic [K-1:0] cell_in;
      for (genvar j = 0; j < K; j++) begin : g_pin
        if (c * K + j < N_IN) begin : g_used
          assign cell_in[j] = node[OFF_IN + c * K + j];
        end else begin : g_tied
          assign cell_in[j] = 1'b0;
        end
      end
      assign node[OFF_OUT + c] = lut_xor(cell_in);
    end
  end

  assign dout_comb = node[TOTAL-1];

  // ---- stage p0 -> p1: capture parity when din is qualified ----
  logic parity_p1_d;
  logic parity_p1_q;
  logic vld_p1_d;
  logic vld_p1_q;

  // Next-state: load parity on valid input, otherwise hold it; valid is a pulse.
  always_comb begin
    parity_p1_d = parity_p1_q;
    vld_p1_d    = 1'b0;
    if (din_valid) begin
      parity_p1_d = dout_comb;
      vld_p1_d    = 1'b1;
    end
  end

  // Output registers; reset wins over a coincident din_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_p1_q <= 1'b0;
      vld_p1_q    <= 1'b0;
    end else begin
      parity_p1_q <= parity_p1_d;
      vld_p1_q    <= vld_p1_d;
    end
  end

  assign dout       = parity_p1_q;
  assign dout_valid = vld_p1_q;

endmodule

// File: tb/tb_xor_lut_unit.sv
// tb_xor_lut_unit: drives several xor_lut_unit configurations from one shared
// stimulus bus and compares every output against a popcount-based model.
module tb_xor_lut_unit;

  localparam int N_INST = 12;
  localparam int W_TAB [N_INST] = '{6, 13, 1, 5, 7, 24, 36, 1, 5, 7, 24, 36};
  localparam int T_TAB [N_INST] = '{2, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2};

  logic              clk = 1'b0;
  logic              rst;
  logic              din_valid;
  logic [35:0]       din;
  logic [N_INST-1:0] comb_o;
  logic [N_INST-1:0] dout_o;
  logic [N_INST-1:0] vld_o;

  logic m_dout [N_INST];
  logic m_vld  [N_INST];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N_INST; i++) begin : g_dut
    localparam int W = W_TAB[i];
    xor_lut_unit #(
      .WIDTH       (W),
      .TARGET_CHIP (T_TAB[i])
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (din_valid),
      .din        (din[W-1:0]),
      .dout_comb  (comb_o[i]),
      .dout       (dout_o[i]),
      .dout_valid (vld_o[i])
    );
  end

  // Reference parity: count the ones in the low w bits, take it modulo 2.
  function automatic logic ref_par(input logic [35:0] v, input int w);
    int ones;
    ones = 0;
    for (int k = 0; k < w; k++) begin
      if (v[k]) ones = ones + 1;
    end
    return logic'(ones % 2);
  endfunction

  task automatic chk(input string tag, input logic got, input logic exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      if (n_bad <= 40) $display("FAIL %s got=%b want=%b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [35:0] d);
    rst       = r;
    din_valid = v;
    din       = d;
  endtask

  // One clock: check combinational outputs, advance the model, check registers.
  task automatic step();
    #1;
    for (int i = 0; i < N_INST; i++) begin
      chk($sformatf("comb w%0d tc%0d", W_TAB[i], T_TAB[i]), comb_o[i], ref_par(din, W_TAB[i]));
    end
    for (int i = 0; i < N_INST; i++) begin
      if (rst) begin
        m_dout[i] = 1'b0;
        m_vld[i]  = 1'b0;
      end else if (din_valid) begin
        m_dout[i] = ref_par(din, W_TAB[i]);
        m_vld[i]  = 1'b1;
      end else begin
        m_vld[i]  = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N_INST; i++) begin
      chk($sformatf("dout w%0d tc%0d", W_TAB[i], T_TAB[i]), dout_o[i], m_dout[i]);
      chk($sformatf("vld w%0d tc%0d", W_TAB[i], T_TAB[i]), vld_o[i], m_vld[i]);
    end
  endtask

  initial begin
    logic [63:0] rv;
    for (int i = 0; i < N_INST; i++) begin
      m_dout[i] = 1'b0;
      m_vld[i]  = 1'b0;
    end
    drive(1'b1, 1'b0, 36'h0);
    @(posedge clk);
    #1;
    step();
    step();
    chk("reset dout", dout_o[0], 1'b0);
    chk("reset vld", vld_o[0], 1'b0);

    // 6'b101101 has even parity
    drive(1'b0, 1'b1, 36'h2D);
    #1;
    chk("ex1 comb", comb_o[0], 1'b0);
    step();
    chk("ex1 dout", dout_o[0], 1'b0);
    chk("ex1 vld", vld_o[0], 1'b1);

    // 6'b000111 has odd parity
    drive(1'b0, 1'b1, 36'h07);
    #1;
    chk("ex2 comb", comb_o[0], 1'b1);
    step();
    chk("ex2 dout", dout_o[0], 1'b1);

    // Sweep all 64 patterns of the low six bits, back to back
    for (int v = 0; v < 64; v++) begin
      rv = {$urandom(), $urandom()};
      drive(1'b0, 1'b1, {rv[35:6], 6'(v)});
      step();
    end

    // 13-bit, 4-input cells: 4 groups with a 1-bit last group
    drive(1'b0, 1'b1, 36'h1000);
    #1;
    chk("w13 h1000 comb", comb_o[1], 1'b1);
    step();
    chk("w13 h1000 dout", dout_o[1], 1'b1);
    drive(1'b0, 1'b1, 36'h1FFF);
    #1;
    chk("w13 h1fff comb", comb_o[1], 1'b1);
    step();
    chk("w13 h1fff dout", dout_o[1], 1'b1);
    drive(1'b0, 1'b1, 36'h0FFF);
    #1;
    chk("w13 h0fff comb", comb_o[1], 1'b0);
    step();
    chk("w13 h0fff dout", dout_o[1], 1'b0);

    // Reset drops a coincident valid; capture resumes once rst is low
    drive(1'b1, 1'b1, 36'h1);
    step();
    chk("rst drop dout", dout_o[0], 1'b0);
    chk("rst drop vld", vld_o[0], 1'b0);
    drive(1'b0, 1'b1, 36'h1);
    step();
    chk("post rst dout", dout_o[0], 1'b1);
    chk("post rst vld", vld_o[0], 1'b1);

    // Hold: no valid for three cycles while din keeps changing
    drive(1'b0, 1'b1, 36'h1);
    step();
    for (int h = 0; h < 3; h++) begin
      rv = {$urandom(), $urandom()};
      drive(1'b0, 1'b0, rv[35:0]);
      step();
      chk("hold dout", dout_o[0], 1'b1);
      chk("hold vld", vld_o[0], 1'b0);
    end

    // Random traffic with occasional resets
    for (int n = 0; n < 10000; n++) begin
      rv = {$urandom(), $urandom()};
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), rv[35:0]);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
